// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: counts rising threshold crossings of a neuron level over
// fixed windows and queues one {tag, count} record per window in an FWFT FIFO.
module spike_rate_monitor #(
  parameter int THRESH = 8,
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               node_out,
  input  logic                     enable,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [CNT_W-1:0]         rec_count,
  output logic [TAG_W-1:0]         rec_tag,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int WIN_W = $clog2(WINDOW);
  localparam int REC_W = TAG_W + CNT_W;
  localparam logic [3:0]       THR      = 4'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic inc);
    logic [CNT_W-1:0] res;
    if (inc && (cnt != CNT_MAX)) begin
      res = cnt + CNT_W'(1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  logic             prev_hi_r;
  logic [WIN_W-1:0] win_cnt_r;
  logic [CNT_W-1:0] spike_cnt_r;
  logic [TAG_W-1:0] tag_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             overflow_r;
  logic [REC_W-1:0] mem_r [DEPTH];

  logic             hi_s;
  logic             event_s;
  logic             close_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             full_s;
  logic             pop_s;
  logic             push_ok_s;
  logic             drop_s;
  logic [REC_W-1:0] head_s;

  // Event detection, window close and FIFO accept/drop decisions.
  always_comb begin
    hi_s       = enable & (node_out >= THR);
    event_s    = hi_s & ~prev_hi_r;
    close_s    = enable & (win_cnt_r == WIN_LAST);
    cnt_next_s = sat_inc(spike_cnt_r, event_s);
    full_s     = (level_r == LVL_FULL);
    pop_s      = rec_valid & rec_ready;
    push_ok_s  = close_s & (~full_s | pop_s);
    drop_s     = close_s & full_s & ~pop_s;
  end

  // Window counter, per-window spike count and sequence tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_hi_r   <= 1'b0;
      win_cnt_r   <= '0;
      spike_cnt_r <= '0;
      tag_r       <= '0;
    end else begin
      prev_hi_r <= hi_s;
      if (close_s) begin
        win_cnt_r   <= '0;
        spike_cnt_r <= '0;
        tag_r       <= tag_r + TAG_W'(1);
      end else if (enable) begin
        win_cnt_r   <= win_cnt_r + WIN_W'(1);
        spike_cnt_r <= cnt_next_s;
      end
    end
  end

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Record storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= {tag_r, cnt_next_s};
    end
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (rec_valid) begin
      rec_count = head_s[CNT_W-1:0];
      rec_tag   = head_s[REC_W-1:CNT_W];
    end else begin
      rec_count = '0;
      rec_tag   = '0;
    end
  end

  assign rec_valid  = (level_r != '0);
  assign fifo_level = level_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Bench for spike_rate_monitor: a queue-based window/record model checked every
// cycle against a default instance and a 2-bit-count instance, plus directed literals.
module tb_spike_rate_monitor;

  localparam int WINDOW = 16;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] node_out = 4'd0;
  logic       enable = 1'b0;
  logic       rec_ready = 1'b0;

  logic       rec_valid, ovf;
  logic [7:0] rec_count;
  logic [3:0] rec_tag;
  logic [2:0] fifo_level;

  logic       s_valid, s_ovf;
  logic [1:0] s_count;
  logic [3:0] s_tag;
  logic [2:0] s_level;

  int checks = 0;
  int failures = 0;

  spike_rate_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .node_out(node_out), .enable(enable),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_count(rec_count),
    .rec_tag(rec_tag), .fifo_level(fifo_level), .overflow(ovf)
  );

  spike_rate_monitor #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .node_out(node_out), .enable(enable),
    .rec_valid(s_valid), .rec_ready(rec_ready), .rec_count(s_count),
    .rec_tag(s_tag), .fifo_level(s_level), .overflow(s_ovf)
  );

  always #5 clk = ~clk;

  // Reference: unsaturated event totals per window, saturation applied on read.
  int m_prev = 0, m_win = 0, m_total = 0, m_tag = 0, m_ovf = 0;
  int m_hi, m_ev;
  int q_tag[$];
  int q_tot[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_prev = 0; m_win = 0; m_total = 0; m_tag = 0; m_ovf = 0;
      q_tag.delete(); q_tot.delete();
    end else begin
      m_hi = (enable && (node_out >= 4'd8)) ? 1 : 0;
      m_ev = (m_hi == 1 && m_prev == 0) ? 1 : 0;
      if (q_tag.size() != 0 && rec_ready) begin
        void'(q_tag.pop_front());
        void'(q_tot.pop_front());
      end
      if (enable) begin
        if (m_win == WINDOW - 1) begin
          if (q_tag.size() < DEPTH) begin
            q_tag.push_back(m_tag);
            q_tot.push_back(m_total + m_ev);
          end else begin
            m_ovf = 1;
          end
          m_tag = (m_tag + 1) % 16;
          m_total = 0;
          m_win = 0;
        end else begin
          m_total += m_ev;
          m_win++;
        end
      end
      m_prev = m_hi;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic compare_all();
    int n, et, ec;
    n  = q_tag.size();
    et = (n != 0) ? q_tag[0] : 0;
    ec = (n != 0) ? q_tot[0] : 0;
    check("valid",     32'(rec_valid),  32'(n != 0));
    check("count",     32'(rec_count),  32'(sat(ec, 255)));
    check("tag",       32'(rec_tag),    32'(et));
    check("level",     32'(fifo_level), 32'(n));
    check("overflow",  32'(ovf),        32'(m_ovf));
    check("s_valid",   32'(s_valid),    32'(n != 0));
    check("s_count",   32'(s_count),    32'(sat(ec, 3)));
    check("s_tag",     32'(s_tag),      32'(et));
    check("s_level",   32'(s_level),    32'(n));
    check("s_overflow",32'(s_ovf),      32'(m_ovf));
  endtask

  task automatic step(input bit r, input int node, input bit en, input bit rdy);
    rst_n = r; node_out = node[3:0]; enable = en; rec_ready = rdy;
    @(posedge clk);
    #3;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b0, 15, 1'b1, 1'b0);
    step(1'b0, 15, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset with a high input and enable: everything reads zero.
    do_reset();
    check("rst_valid", 32'(rec_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_count", 32'(rec_count), 32'd0);

    // Pattern 0,0,9,9: four events, record appears after the 16th enabled edge.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, ((i % 4) >= 2) ? 9 : 0, 1'b1, 1'b0);
      if (i == 14) check("lat_not_yet", 32'(rec_valid), 32'd0);
    end
    check("pat_valid", 32'(rec_valid), 32'd1);
    check("pat_count", 32'(rec_count), 32'd4);
    check("pat_tag", 32'(rec_tag), 32'd0);
    step(1'b1, 0, 1'b0, 1'b1);
    check("pat_pop_level", 32'(fifo_level), 32'd0);

    // Held-high input counts once per continuous high stretch.
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 15, 1'b1, 1'b0);
    check("hold_level", 32'(fifo_level), 32'd2);
    check("hold_c0", 32'(rec_count), 32'd1);
    step(1'b1, 0, 1'b0, 1'b1);
    check("hold_t1", 32'(rec_tag), 32'd1);
    check("hold_c1", 32'(rec_count), 32'd0);
    step(1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 15, 1'b1, 1'b0);
    step(1'b1, 15, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 15, 1'b1, 1'b0);
    check("reen_tag", 32'(rec_tag), 32'd2);
    check("reen_count", 32'(rec_count), 32'd2);
    step(1'b1, 0, 1'b0, 1'b1);

    // Overflow: five windows with no draining.
    do_reset();
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 16; i++) step(1'b1, (i == 0) ? 9 : 0, 1'b1, 1'b0);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag", 32'(ovf), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("ovf_drain_tag", 32'(rec_tag), 32'(k));
      step(1'b1, 0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 16; i++) step(1'b1, (i == 0) ? 9 : 0, 1'b1, 1'b0);
    check("gap_tag", 32'(rec_tag), 32'd5);
    check("gap_ovf", 32'(ovf), 32'd1);

    // Saturation on the narrow instance, and an event on the close cycle.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, (i < 10 && (i % 2) == 0) ? 9 : 0, 1'b1, 1'b0);
    check("sat_wide", 32'(rec_count), 32'd5);
    check("sat_narrow", 32'(s_count), 32'd3);
    step(1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, (i == 11 || i == 13 || i == 15) ? 9 : 0, 1'b1, 1'b0);
    check("close_evt", 32'(rec_count), 32'd3);
    step(1'b1, 0, 1'b0, 1'b1);

    // Full FIFO popped exactly on a close cycle, then a mid-window reset.
    do_reset();
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 16; i++)
        step(1'b1, (i == 0) ? 9 : 0, 1'b1, (w == 4 && i == 15));
    check("fullpop_level", 32'(fifo_level), 32'd4);
    check("fullpop_ovf", 32'(ovf), 32'd0);
    check("fullpop_head", 32'(rec_tag), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, (i == 0) ? 9 : 0, 1'b1, 1'b0);
    check("rst_mid_level", 32'(fifo_level), 32'd1);
    check("rst_mid_tag", 32'(rec_tag), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 15),
           $urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
